servant_gpio_bank: RTL
======================

# servant_gpio_bank

Wishbone-slave GPIO bank for the servant SoC, the parametrised successor of the fixed output-only GPIO port. It provides NUM_GPIO bidirectional pins with per-bit direction, atomic set/clear, two-flop input synchronisation, per-bit edge detection and a level interrupt. It sits on the servant peripheral bus beside the timer and drives the `q` pins of the SoC top.

## Interface
- NUM_GPIO, 8: number of pins, 1..32.
- ADR_WIDTH_GPIO, 3: word-address bits decoded; must be ≥3; registers above word 7 are unmapped.
- wb_clk  in  1  system clock.
- wb_rst  in  1  asynchronous, active-high reset.
- i_wb_adr  in  ADR_WIDTH_GPIO  word address.
- i_wb_dat  in  32  write data.
- i_wb_we  in  1  write enable.
- i_wb_cyc  in  1  cycle request; the bus has no separate strobe.
- o_wb_rdt  out  32  read data, valid while o_wb_ack is high.
- o_wb_ack  out  1  single-cycle acknowledge.
- i_gpio  in  NUM_GPIO  pad inputs, asynchronous to wb_clk.
- o_gpio  out  NUM_GPIO  output data register.
- o_gpio_oe  out  NUM_GPIO  output enable; 1 = drive.
- o_irq  out  1  interrupt request.

## Operation
- Register map (word address):
  - 0 OUT: R/W.
  - 1 DIR: R/W.
  - 2 IN: RO synchronised pins.
  - 3 IRQ_EN: R/W.
  - 4 IRQ_STATUS: R; write-1-to-clear.
  - 5 EDGE_SEL: R/W; 0 = rising, 1 = falling.
  - 6 SET: WO; OUT |= data.
  - 7 CLR: WO; OUT &= ~data.
  - Unmapped addresses and write-only registers read 0.
- Bits [31:NUM_GPIO] read 0; writes to them are ignored. Writes to IN are ignored.
- Input path: sync1 ← i_gpio; sync2 ← sync1; prev ← sync2. IN reads sync2.
  - Rising edge on bit i: sync2[i] & ~prev[i].
  - Falling edge on bit i: ~sync2[i] & prev[i].
  - A detected edge of the selected polarity sets IRQ_STATUS[i].
- Edge detection runs regardless of DIR. Output pins loop back through i_gpio at board level.
- o_irq = |(IRQ_STATUS & IRQ_EN), combinational from registers.
- Reset values:
  - Outputs o_gpio, o_gpio_oe, o_wb_ack, o_wb_rdt, o_irq are 0.
  - Registers OUT, DIR, IRQ_EN, IRQ_STATUS, EDGE_SEL, sync1, sync2 and prev are 0.
- Pins held high through reset produce a rising edge 3 cycles after reset release. This sets status; firmware clears status before enabling interrupts.

## Timing
- Bus handshake:
  - o_wb_ack is registered, and high for one cycle on the edge after i_wb_cyc & ~o_wb_ack.
  - Back-to-back transfers take 2 cycles each.
  - If i_wb_cyc drops before ack, ack is still issued the next cycle and must be ignored by the master.
- Writes commit on the same edge that raises o_wb_ack. o_gpio and o_gpio_oe change on that edge.
- o_wb_rdt is registered on the same edge as ack from the current register contents. A read therefore returns the value before any same-edge status update.
- Input latency: a pin change that is stable before edge N appears in IN after edge N+1. IRQ_STATUS sets at edge N+2, and o_irq follows combinationally.
- Simultaneous events:
  - W1C of bit i on the same edge a new edge is detected on bit i: the set wins and the bit stays 1.
  - EDGE_SEL written on the same edge as detection: the old polarity applies.
- Reset asserted mid-transfer: ack and rdt clear immediately and the transfer is lost.

## Configuration
- SERVANT_GPIO_IRQ_EN defined:
  - IRQ_EN, IRQ_STATUS, EDGE_SEL, prev and the edge logic are present.
  - o_irq behaves as above.
- SERVANT_GPIO_IRQ_EN undefined:
  - Those registers are removed; addresses 3–5 read 0 and ignore writes.
  - o_irq is tied 0.
  - The sync1/sync2 synchroniser and IN remain.

## Test plan
- Reset, then read all 8 addresses with NUM_GPIO=8 → every read returns 0x00000000 and o_irq=0; each ack lasts exactly 1 cycle.
- Write OUT=0xA5, SET=0x0A, CLR=0x81, DIR=0xFF → OUT reads 0x2E; o_gpio=0x2E and o_gpio_oe=0xFF from each write's ack edge.
- Set IRQ_EN=0x01 and EDGE_SEL=0; raise i_gpio[0] before edge N → IN[0]=1 after edge N+1; STATUS=0x01 and o_irq=1 after edge N+2.
- Set EDGE_SEL=0x02 and IRQ_EN=0x02; pulse i_gpio[1] high then low → no status on the rise; the fall sets STATUS=0x02. Writing 0x02 to STATUS clears it and drops o_irq.
- Issue a W1C of bit 0 on the same edge a new rising edge on bit 0 is detected → STATUS[0] stays 1.
- Build without SERVANT_GPIO_IRQ_EN, write 0xFF to addresses 3–5 and toggle the pins → those reads return 0 and o_irq stays 0.

Source files
------------

// File: rtl/servant_gpio_bank.sv
// servant_gpio_bank: Wishbone GPIO bank with per-bit direction, set/clear and synchronised inputs.
// Edge-detect interrupt registers exist only when SERVANT_GPIO_IRQ_EN is defined.
module servant_gpio_bank #(
    parameter int NUM_GPIO       = 8,
    parameter int ADR_WIDTH_GPIO = 3
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst,
    input  logic [ADR_WIDTH_GPIO-1:0] i_wb_adr,
    input  logic [31:0]               i_wb_dat,
    input  logic                      i_wb_we,
    input  logic                      i_wb_cyc,
    output logic [31:0]               o_wb_rdt,
    output logic                      o_wb_ack,
    input  logic [NUM_GPIO-1:0]       i_gpio,
    output logic [NUM_GPIO-1:0]       o_gpio,
    output logic [NUM_GPIO-1:0]       o_gpio_oe,
    output logic                      o_irq
);
    logic [NUM_GPIO-1:0]       out_q, out_d, dir_q, sync1_q, sync2_q, wd, rsel;
    logic [ADR_WIDTH_GPIO-1:0] hi;
    logic [2:0]                a;
    logic                      acc, mapped, wr;
    logic [31:0]               rdt_d;

    assign hi        = i_wb_adr >> 3;
    assign a         = i_wb_adr[2:0];
    assign mapped    = hi == '0;
    assign acc       = i_wb_cyc & ~o_wb_ack;
    assign wr        = acc & i_wb_we & mapped;
    assign wd        = i_wb_dat[NUM_GPIO-1:0];
    assign o_gpio    = out_q;
    assign o_gpio_oe = dir_q;

    always_comb
        out_d = (wr && a == 3'd0) ? wd :
                (wr && a == 3'd6) ? out_q | wd :
                (wr && a == 3'd7) ? out_q & ~wd : out_q;

`ifdef SERVANT_GPIO_IRQ_EN
    logic [NUM_GPIO-1:0] ien_q, sts_q, sts_d, esel_q, prev_q, edg;

    // a freshly detected edge overrides a same-cycle write-1-to-clear
    always_comb begin
        edg   = (esel_q & ~sync2_q & prev_q) | (~esel_q & sync2_q & ~prev_q);
        sts_d = (sts_q & ~((wr && a == 3'd4) ? wd : '0)) | edg;
    end

    always_ff @(posedge wb_clk or posedge wb_rst)
        if (wb_rst) begin
            ien_q  <= '0;
            sts_q  <= '0;
            esel_q <= '0;
            prev_q <= '0;
        end else begin
            prev_q <= sync2_q;
            sts_q  <= sts_d;
            if (wr && a == 3'd3) ien_q <= wd;
            if (wr && a == 3'd5) esel_q <= wd;
        end

    assign o_irq = |(sts_q & ien_q);
`else
    assign o_irq = 1'b0;
`endif

    always_comb begin
        rsel = '0;
        case (a)
            3'd0:    rsel = out_q;
            3'd1:    rsel = dir_q;
            3'd2:    rsel = sync2_q;
`ifdef SERVANT_GPIO_IRQ_EN
            3'd3:    rsel = ien_q;
            3'd4:    rsel = sts_q;
            3'd5:    rsel = esel_q;
`endif
            default: rsel = '0;
        endcase
        rdt_d = mapped ? 32'(rsel) : '0;
    end

    always_ff @(posedge wb_clk or posedge wb_rst)
        if (wb_rst) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            out_q    <= '0;
            dir_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
        end else begin
            o_wb_ack <= acc;
            o_wb_rdt <= acc ? rdt_d : '0;
            out_q    <= out_d;
            if (wr && a == 3'd1) dir_q <= wd;
            sync1_q  <= i_gpio;
            sync2_q  <= sync1_q;
        end
endmodule
